// File: rtl/remote_cmd_sched.sv
// Round-robin scheduler feeding one UART command transmitter, with ACK/NACK/timeout retry.
// Define REMOTE_CMD_SCHED_STATS_EN to build the saturating ack/retry/fail counters.
module remote_cmd_sched #(
    parameter int unsigned TIMEOUT_CYC = 1000000,
    parameter int unsigned MAX_RETRY   = 2,
    parameter logic [7:0]  ACK_BYTE    = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic [15:0] cmd0,
    input  logic        req1,
    input  logic [15:0] cmd1,
    output logic        done0,
    output logic        fail0,
    output logic        done1,
    output logic        fail1,
    output logic        busy,
    output logic        snd_cmd,
    output logic [15:0] cmd,
    input  logic        cmd_snt,
    input  logic        resp_rdy,
    input  logic [7:0]  resp,
    output logic        clr_resp_rdy,
    output logic [15:0] stat_ack,
    output logic [15:0] stat_retry,
    output logic [15:0] stat_fail
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);

    typedef enum logic [2:0] {IDLE, SEND, WAIT_SNT, WAIT_RESP, DONE} state_e;

    state_e        state_q, state_d;
    logic [15:0]   cmd_q, cmd_d;
    logic          owner_q, owner_d;
    logic          last_gnt_q, last_gnt_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    pulse_q, pulse_d;   // {fail1, done1, fail0, done0}

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            owner_q    <= 1'b0;
            last_gnt_q <= 1'b1;
            retry_q    <= '0;
            cnt_q      <= '0;
            pulse_q    <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            owner_q    <= owner_d;
            last_gnt_q <= last_gnt_d;
            retry_q    <= retry_d;
            cnt_q      <= cnt_d;
            pulse_q    <= pulse_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        owner_d    = owner_q;
        last_gnt_d = last_gnt_q;
        retry_d    = retry_q;
        cnt_d      = cnt_q;
        pulse_d    = '0;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    owner_d = (req0 && req1) ? ~last_gnt_q : req1;
                    cmd_d   = owner_d ? cmd1 : cmd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                cnt_d   = '0;
                state_d = WAIT_SNT;
            end
            WAIT_SNT: begin
                // cnt marks the first cycle, while cmd_snt from the last attempt may still be high
                if (cnt_q == '0) begin
                    cnt_d = CW'(1);
                end else if (cmd_snt) begin
                    cnt_d   = '0;
                    state_d = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                cnt_d = cnt_q + CW'(1);
                if (resp_rdy && resp == ACK_BYTE) begin
                    pulse_d = owner_q ? 4'b0100 : 4'b0001;
                    state_d = DONE;
                end else if (resp_rdy || cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d = retry_q + RW'(1);
                        state_d = SEND;
                    end else begin
                        pulse_d = owner_q ? 4'b1000 : 4'b0010;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                last_gnt_d = owner_q;
                retry_d    = '0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy         = (state_q != IDLE);
    assign snd_cmd      = (state_q == SEND);
    assign cmd          = cmd_q;
    assign done0        = pulse_q[0];
    assign fail0        = pulse_q[1];
    assign done1        = pulse_q[2];
    assign fail1        = pulse_q[3];
    // Any response byte is consumed immediately; outside WAIT_RESP it is simply dropped.
    assign clr_resp_rdy = resp_rdy;

`ifdef REMOTE_CMD_SCHED_STATS_EN
    logic [15:0] stat_ack_q, stat_ack_d;
    logic [15:0] stat_retry_q, stat_retry_d;
    logic [15:0] stat_fail_q, stat_fail_d;
    logic        ev_retry;

    assign ev_retry = (state_q == WAIT_RESP) && (state_d == SEND);

    always_comb begin
        stat_ack_d   = stat_ack_q;
        stat_retry_d = stat_retry_q;
        stat_fail_d  = stat_fail_q;
        if ((pulse_d[0] || pulse_d[2]) && stat_ack_q != 16'hFFFF)
            stat_ack_d = stat_ack_q + 16'd1;
        if (ev_retry && stat_retry_q != 16'hFFFF)
            stat_retry_d = stat_retry_q + 16'd1;
        if ((pulse_d[1] || pulse_d[3]) && stat_fail_q != 16'hFFFF)
            stat_fail_d = stat_fail_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ack_q   <= '0;
            stat_retry_q <= '0;
            stat_fail_q  <= '0;
        end else begin
            stat_ack_q   <= stat_ack_d;
            stat_retry_q <= stat_retry_d;
            stat_fail_q  <= stat_fail_d;
        end
    end

    assign stat_ack   = stat_ack_q;
    assign stat_retry = stat_retry_q;
    assign stat_fail  = stat_fail_q;
`else
    assign stat_ack   = '0;
    assign stat_retry = '0;
    assign stat_fail  = '0;
`endif

endmodule

// File: tb/tb_remote_cmd_sched.sv
// Bench for remote_cmd_sched: a behavioural transmitter/responder drives scripted ACK/NACK/timeout
// per attempt; table vectors, random transactions and hand-written corner sequences are scored.
module tb_remote_cmd_sched;
    localparam int TMO  = 100;
    localparam int MAXR = 2;
    localparam logic [1:0] C_ACK = 2'd0, C_NACK = 2'd1, C_TMO = 2'd2;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [15:0] cmd0 = '0, cmd1 = '0;
    logic        cmd_snt = 1'b0, resp_rdy = 1'b0;
    logic [7:0]  resp = '0;
    logic        done0, fail0, done1, fail1, busy, snd_cmd, clr_resp_rdy;
    logic [15:0] cmd, stat_ack, stat_retry, stat_fail;

    remote_cmd_sched #(.TIMEOUT_CYC(TMO), .MAX_RETRY(MAXR), .ACK_BYTE(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .cmd0(cmd0), .req1(req1), .cmd1(cmd1),
        .done0(done0), .fail0(fail0), .done1(done1), .fail1(fail1), .busy(busy),
        .snd_cmd(snd_cmd), .cmd(cmd), .cmd_snt(cmd_snt), .resp_rdy(resp_rdy), .resp(resp),
        .clr_resp_rdy(clr_resp_rdy), .stat_ack(stat_ack), .stat_retry(stat_retry),
        .stat_fail(stat_fail)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    int cyc = 0, snd_cnt = 0, clr_cnt = 0;
    int done_cnt [2] = '{0, 0};
    int fail_cnt [2] = '{0, 0};
    logic [15:0] snd_log [$];
    logic [1:0]  code_q [$];
    int snt_delay = 1, resp_delay = 0;
    bit stale_inject = 1'b0;
    // reference totals and last owner, from the transaction-level model
    int tot_ack = 0, tot_retry = 0, tot_fail = 0;
    int last_owner = 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [5:0] p3(input logic [1:0] a0, input logic [1:0] a1, input logic [1:0] a2);
        return {a2, a1, a0};
    endfunction

    // Attempts end at the first ACK, or after MAXR+1 attempts with none.
    function automatic void model(input logic [5:0] pat, output int att, output bit ok, output int nresp);
        att = MAXR + 1; ok = 1'b0; nresp = 0;
        for (int i = 0; i <= MAXR; i++) begin
            if (pat[2*i +: 2] != C_TMO) nresp++;
            if (pat[2*i +: 2] == C_ACK) begin
                att = i + 1; ok = 1'b1; break;
            end
        end
    endfunction

    task automatic chk_stats(input string tag);
`ifdef REMOTE_CMD_SCHED_STATS_EN
        chk({tag, "_stat_ack"}, stat_ack, tot_ack);
        chk({tag, "_stat_retry"}, stat_retry, tot_retry);
        chk({tag, "_stat_fail"}, stat_fail, tot_fail);
`else
        chk({tag, "_stat_zero"}, {stat_ack, stat_retry, stat_fail}, 48'd0);
`endif
    endtask

    // Remote side: transmitter completes sd cycles after snd_cmd, responder answers rd cycles later.
    initial begin : remote
        int snt_wait, resp_wait, stale_wait, snt_cyc;
        bit tmo_armed, snt_seen;
        logic [1:0] code;
        snt_wait = -1; resp_wait = -1; stale_wait = -1; snt_cyc = 0;
        tmo_armed = 1'b0; snt_seen = 1'b0; code = C_ACK;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                cmd_snt = 1'b0; resp_rdy = 1'b0;
                snt_wait = -1; resp_wait = -1; stale_wait = -1;
                tmo_armed = 1'b0; snt_seen = 1'b0;
            end else begin
                if (resp_rdy && clr_resp_rdy) begin
                    resp_rdy = 1'b0; clr_cnt++;
                end
                if (done0 || fail0 || done1 || fail1) begin
                    chk("verdict_after_snt", snt_seen, 1);
                    if ((fail0 || fail1) && tmo_armed) begin
                        chk("tmo_gap_fail", cyc - snt_cyc, TMO + 1);
                        tmo_armed = 1'b0;
                    end
                    if (done0) done_cnt[0]++;
                    if (fail0) fail_cnt[0]++;
                    if (done1) done_cnt[1]++;
                    if (fail1) fail_cnt[1]++;
                end
                if (snd_cmd) begin
                    if (tmo_armed) begin
                        chk("tmo_gap_retry", cyc - snt_cyc, TMO + 1);
                        tmo_armed = 1'b0;
                    end
                    snd_cnt++;
                    snd_log.push_back(cmd);
                    cmd_snt = 1'b0; snt_seen = 1'b0;
                    snt_wait = snt_delay; resp_wait = -1;
                    code = (code_q.size() > 0) ? code_q.pop_front() : C_ACK;
                    if (stale_inject) stale_wait = 1;
                end else if (snt_wait == 0) begin
                    cmd_snt = 1'b1; snt_seen = 1'b1; snt_wait = -1; snt_cyc = cyc;
                    if (code == C_TMO) tmo_armed = 1'b1;
                    else resp_wait = resp_delay;
                end else if (snt_wait > 0) begin
                    snt_wait--;
                end else if (resp_wait == 0) begin
                    resp_rdy = 1'b1;
                    resp = (code == C_ACK) ? 8'hA5 : 8'h5A;
                    resp_wait = -1;
                end else if (resp_wait > 0) begin
                    resp_wait--;
                end
                if (stale_wait == 0) begin
                    resp_rdy = 1'b1; resp = 8'hA5; stale_wait = -1;
                end else if (stale_wait > 0) begin
                    stale_wait--;
                end
            end
        end
    end

    task automatic run_txn(input string tag, input int who, input logic [15:0] c, input logic [5:0] pat,
                           input int sd, input int rd, input int e_att, input bit e_ok,
                           input int e_nresp, input bit stale);
        int s0, c0, d0, f0, n;
        code_q.delete();
        for (int i = 0; i <= MAXR; i++) code_q.push_back(pat[2*i +: 2]);
        snt_delay = sd; resp_delay = rd; stale_inject = stale;
        snd_log.delete();
        s0 = snd_cnt; c0 = clr_cnt; d0 = done_cnt[who]; f0 = fail_cnt[who];
        if (who == 0) begin cmd0 = c; req0 = 1'b1; end
        else begin cmd1 = c; req1 = 1'b1; end
        n = 0;
        while (done_cnt[who] == d0 && fail_cnt[who] == f0 && n < 3000) begin
            @(posedge clk); #1; n++;
        end
        req0 = 1'b0; req1 = 1'b0; stale_inject = 1'b0;
        chk({tag, "_finished"}, n < 3000, 1);
        chk({tag, "_attempts"}, snd_cnt - s0, e_att);
        chk({tag, "_done"}, done_cnt[who] - d0, e_ok);
        chk({tag, "_fail"}, fail_cnt[who] - f0, !e_ok);
        chk({tag, "_clr"}, clr_cnt - c0, e_nresp + stale);
        for (int i = 0; i < snd_log.size(); i++) chk({tag, "_cmd"}, snd_log[i], c);
        @(posedge clk); #1;
        chk({tag, "_busy_after"}, busy, 0);
        tot_ack += e_ok; tot_fail += !e_ok; tot_retry += e_att - 1;
        last_owner = who;
        chk_stats(tag);
    endtask

    typedef struct {
        int          who;
        logic [15:0] c;
        logic [5:0]  pat;
        int          sd;
        int          rd;
        int          att;
        bit          ok;
        int          nresp;
    } vec_t;

    initial begin : main
        vec_t tbl [7];
        int att, nresp, n, s0, d0, f0, dd1, ff1, idle_run, max_idle, first;
        bit ok, seen;
        logic [5:0] pat;

        tbl[0] = '{0, 16'h2345, p3(C_ACK,  C_ACK,  C_ACK),  30, 3,  1, 1'b1, 1};
        tbl[1] = '{0, 16'h4000, p3(C_NACK, C_NACK, C_ACK),  5,  2,  3, 1'b1, 3};
        tbl[2] = '{1, 16'hBEEF, p3(C_TMO,  C_TMO,  C_TMO),  4,  0,  3, 1'b0, 0};
        tbl[3] = '{1, 16'h0001, p3(C_ACK,  C_ACK,  C_ACK),  2,  99, 1, 1'b1, 1};
        tbl[4] = '{0, 16'hFFFF, p3(C_NACK, C_NACK, C_NACK), 1,  0,  3, 1'b0, 3};
        tbl[5] = '{1, 16'h0F0F, p3(C_TMO,  C_ACK,  C_ACK),  7,  10, 2, 1'b1, 1};
        tbl[6] = '{0, 16'h8000, p3(C_NACK, C_TMO,  C_ACK),  3,  50, 3, 1'b1, 2};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_snd_cmd", snd_cmd, 0);
        chk("rst_cmd", cmd, 0);
        chk("rst_pulses", {done0, fail0, done1, fail1}, 0);
        chk("rst_stats", {stat_ack, stat_retry, stat_fail}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++)
            run_txn($sformatf("tbl%0d", i), tbl[i].who, tbl[i].c, tbl[i].pat,
                    tbl[i].sd, tbl[i].rd, tbl[i].att, tbl[i].ok, tbl[i].nresp, 1'b0);

        for (int i = 0; i < 12; i++) begin
            pat = p3(2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)));
            model(pat, att, ok, nresp);
            run_txn($sformatf("rnd%0d", i), int'($urandom_range(0, 1)), 16'($urandom), pat,
                    int'($urandom_range(1, 40)), int'($urandom_range(0, 99)), att, ok, nresp, 1'b0);
        end

        // stale ACK byte during WAIT_SNT must be discarded, the real one later completes
        run_txn("stale", 0, 16'h5555, p3(C_ACK, C_ACK, C_ACK), 10, 4, 1, 1'b1, 1, 1'b1);

        // reset while waiting for a response
        code_q.delete();
        code_q.push_back(C_TMO);
        snt_delay = 3; resp_delay = 0;
        s0 = snd_cnt; d0 = done_cnt[0]; f0 = fail_cnt[0]; dd1 = done_cnt[1]; ff1 = fail_cnt[1];
        cmd0 = 16'hABCD; req0 = 1'b1;
        n = 0;
        while (snd_cnt == s0 && n < 50) begin @(posedge clk); #1; n++; end
        chk("rstmid_started", n < 50, 1);
        repeat (15) @(posedge clk);
        #1;
        chk("rstmid_busy_before", busy, 1);
        rst_n = 1'b0; req0 = 1'b0; cmd1 = 16'h1357; req1 = 1'b1;
        #1;
        chk("rstmid_busy", busy, 0);
        chk("rstmid_snd", snd_cmd, 0);
        chk("rstmid_cmd", cmd, 0);
        chk("rstmid_pulses", {done0, fail0, done1, fail1}, 0);
        chk("rstmid_clr", clr_resp_rdy, 0);
        chk("rstmid_stats", {stat_ack, stat_retry, stat_fail}, 0);
        repeat (2) @(posedge clk);
        #1;
        code_q.delete(); snd_log.delete();
        tot_ack = 0; tot_retry = 0; tot_fail = 0; last_owner = 1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 2 && !seen; i++) begin
            @(posedge clk); #1;
            if (snd_cmd) seen = 1'b1;
        end
        chk("rstmid_regrant_2cyc", seen, 1);
        n = 0;
        while (done_cnt[1] == dd1 && fail_cnt[1] == ff1 && n < 500) begin @(posedge clk); #1; n++; end
        req1 = 1'b0;
        chk("rstmid_done1", done_cnt[1] - dd1, 1);
        chk("rstmid_no_verdict0", (done_cnt[0] - d0) + (fail_cnt[0] - f0), 0);
        chk("rstmid_log_cmd", (snd_log.size() > 0) ? snd_log[0] : 16'h0, 16'h1357);
        tot_ack += 1; last_owner = 1;
        @(posedge clk); #1;
        chk_stats("rstmid");

        // sustained dual requests alternate, one IDLE cycle between commands
        code_q.delete(); snt_delay = 3; resp_delay = 2; snd_log.delete();
        s0 = snd_cnt; d0 = done_cnt[0] + done_cnt[1];
        cmd0 = 16'h1111; cmd1 = 16'h2222; req0 = 1'b1; req1 = 1'b1;
        n = 0; idle_run = 0; max_idle = 0;
        while (n < 2000) begin
            @(posedge clk); #1; n++;
            if (done_cnt[0] + done_cnt[1] - d0 >= 3) break;
            if (snd_cnt > s0) begin
                if (!busy) begin
                    idle_run++;
                    if (idle_run > max_idle) max_idle = idle_run;
                end else idle_run = 0;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("alt_finished", n < 2000, 1);
        chk("alt_nsnd", snd_cnt - s0, 3);
        first = (last_owner == 1) ? 0 : 1;
        for (int i = 0; i < 3; i++)
            chk($sformatf("alt_order%0d", i), (snd_log.size() > i) ? snd_log[i] : 16'h0,
                (((first + i) % 2) == 0) ? 16'h1111 : 16'h2222);
        chk("alt_gap_le1", max_idle <= 1, 1);
        tot_ack += 3; last_owner = first;
        @(posedge clk); #1;
        chk("alt_busy_after", busy, 0);
        chk_stats("alt");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/remote_cmd_sched.md
Name: remote_cmd_sched

Overview:
Schedules 16-bit remote commands from two requesters onto the single two-byte UART command transmitter (snd_cmd/cmd/cmd_snt) and its response receiver.
- Round-robin arbitration between requesters.
- Per command: issue, wait for transmission complete, wait for an acknowledge byte; retry on NACK or timeout, up to a limit.
- Sits between the host-side command sources and the remote-comm transmitter.

Parameters:
TIMEOUT_CYC, 1000000, cycles allowed in WAIT_RESP before a timeout.
MAX_RETRY, 2, retransmissions allowed after the first attempt (total attempts = MAX_RETRY+1).
ACK_BYTE, 8'hA5, response value meaning positive acknowledge.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
req0  input  1  requester 0 command request, level, held until done0/fail0
cmd0  input  16  requester 0 command, sampled at grant
req1  input  1  requester 1 command request, level
cmd1  input  16  requester 1 command, sampled at grant
done0  output  1  one-cycle pulse: requester 0 command acknowledged
fail0  output  1  one-cycle pulse: requester 0 command abandoned
done1  output  1  one-cycle pulse: requester 1 command acknowledged
fail1  output  1  one-cycle pulse: requester 1 command abandoned
busy  output  1  high in every state except IDLE
snd_cmd  output  1  one-cycle pulse to transmitter
cmd  output  16  registered command to transmitter
cmd_snt  input  1  transmitter finished both bytes (level, cleared by snd_cmd)
resp_rdy  input  1  response byte valid
resp  input  8  response byte
clr_resp_rdy  output  1  one-cycle pulse consuming resp_rdy
stat_ack  output  16  acknowledged-command count (optional feature)
stat_retry  output  16  retransmission count (optional feature)
stat_fail  output  16  failed-command count (optional feature)

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: every output 0; state IDLE; last_gnt=1, so req0 wins the first contention; retry count 0.
- FSM states: IDLE, SEND, WAIT_SNT, WAIT_RESP, DONE.
- IDLE, on any req:
  - Grant one requester; round-robin against last_gnt.
  - Latch that requester's cmd into cmd and record the owner.
  - Go to SEND.
- SEND: snd_cmd=1 for exactly one cycle; go to WAIT_SNT. cmd holds stable from grant until DONE.
- WAIT_SNT:
  - Ignore the first cycle (cmd_snt is still clearing).
  - Thereafter, on cmd_snt=1: go to WAIT_RESP and clear the timeout counter.
  - No timeout in this state.
- WAIT_RESP:
  - Counter increments each cycle.
  - On resp_rdy: pulse clr_resp_rdy the same cycle.
    - resp==ACK_BYTE: done pulse to owner.
    - Otherwise: NACK.
  - On counter==TIMEOUT_CYC-1 with no resp_rdy: timeout.
  - NACK or timeout with retries<MAX_RETRY: increment retries, go to SEND with cmd unchanged.
  - NACK or timeout with retries==MAX_RETRY: fail pulse to owner.
  - resp_rdy and timeout in the same cycle: the response wins.
- DONE:
  - The done/fail pulse fires on entry, registered, one cycle wide.
  - Update last_gnt=owner, clear retries, return to IDLE. busy drops the following cycle.
  - A new grant can occur in the cycle after DONE; minimum spacing between snd_cmd pulses of consecutive commands is 4 cycles plus transmit time.
- Stale resp_rdy in IDLE/SEND/WAIT_SNT: pulse clr_resp_rdy, discard the byte, no state effect.
- Requester drops req mid-transaction: the command completes normally and the done/fail pulse still fires. Requester inputs are not re-sampled until IDLE.
- Both reqs high in IDLE: grant the one not equal to last_gnt. Sustained dual requests alternate 0,1,0,1.
- Reset mid-operation: immediate return to IDLE, outputs 0, no done/fail pulse.

Optional Feature:
REMOTE_CMD_SCHED_STATS_EN.
- Defined:
  - stat_ack increments on each done pulse.
  - stat_retry increments on each retransmission.
  - stat_fail increments on each fail pulse.
  - All three saturate at 16'hFFFF and reset to 0.
- Undefined: the three stat ports exist but are tied to 0; no counter logic.

Test Plan:
- req0=1, cmd0=16'h2345; cmd_snt 30 cycles after snd_cmd; resp=8'hA5 -> cmd=16'h2345, exactly one snd_cmd, one clr_resp_rdy, done0 pulse, busy low afterwards.
- req0 and req1 rise the same cycle, cmd0=16'h1111, cmd1=16'h2222, both ACKed, held high -> order 16'h1111, 16'h2222, 16'h1111; no gap longer than one IDLE cycle.
- cmd0=16'h4000; responses 8'h5A, then 8'h5A, then 8'hA5 -> 3 snd_cmd pulses with identical cmd, done0, stat_ack=1, stat_retry=2 with REMOTE_CMD_SCHED_STATS_EN.
- TIMEOUT_CYC=100, no response ever -> 3 attempts each 100 cycles after cmd_snt, fail1, stat_fail=1, stat_retry=2.
- resp_rdy=1 with 8'hA5 while in WAIT_SNT -> clr_resp_rdy pulse, no done; later real 8'hA5 in WAIT_RESP -> done.
- rst_n low while in WAIT_RESP -> all outputs 0 immediately; after release, req1 pending -> fresh grant, snd_cmd within 2 cycles.
